// File: rtl/mesi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mesi_pkg
//  Description : Shared types and constants for the two-core MESI coherence
//                unit (line states, CCU FSM states, system sizes).
//  Revision    : 1.0 - initial release
// ============================================================================
package mesi_pkg;

    localparam int NUM_CORES  = 2;
    localparam int WORD_OFF_W = 2;

    // Line state encoding shared with the L1 controllers
    typedef enum logic [1:0] {
        MESI_M = 2'b00,
        MESI_E = 2'b01,
        MESI_S = 2'b10,
        MESI_I = 2'b11
    } mesi_t;

    // Coherence unit transaction states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SNOOP  = 3'd1,
        ST_WB     = 3'd2,
        ST_MEM_RD = 3'd3,
        ST_RESP   = 3'd4
    } ccu_state_t;

endpackage : mesi_pkg
`default_nettype wire

// File: rtl/ccu_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ccu_rr_arbiter
//  Description : Two-way round-robin arbiter. The core granted most recently
//                loses a tie, and the core just served is masked for the one
//                cycle following its response so a request that is still
//                high while the L1 sees ccu_ready is not granted twice.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccu_rr_arbiter
    import mesi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CORES-1:0] req,
    input  logic                 en,
    input  logic                 served_valid,
    output logic                 grant_id,
    output logic                 grant_valid
);

    logic                 r_last;     // core granted most recently
    logic                 r_mask;     // previous cycle was a response
    logic [NUM_CORES-1:0] w_mask;
    logic [NUM_CORES-1:0] w_req;

    assign w_mask = r_mask ? (r_last ? 2'b10 : 2'b01) : 2'b00;
    assign w_req  = req & ~w_mask;

    // Pick a winner: on a tie the core not served last wins
    always_comb begin
        grant_valid = en && (w_req != 2'b00);
        grant_id    = 1'b0;
        if (w_req == 2'b11) begin
            grant_id = ~r_last;
        end else begin
            grant_id = w_req[1];
        end
    end

    // Track the last grant and the one-cycle post-service mask;
    // reset points the last grant at core 1 so core 0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
            r_mask <= 1'b0;
        end else begin
            if (grant_valid) begin
                r_last <= grant_id;
            end
            r_mask <= served_valid;
        end
    end

endmodule : ccu_rr_arbiter
`default_nettype wire

// File: rtl/mesi_ccu.sv
`default_nettype none
// ============================================================================
//  Module      : mesi_ccu
//  Description : Coherence unit for a two-core MESI system. Arbitrates L1
//                misses, snoops the peer L1 (share or invalidate), writes
//                back dirty snooped words, fetches from memory on a read
//                miss and returns data plus the state to install.
//  Revision    : 1.0 - initial release
// ============================================================================
module mesi_ccu
    import mesi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CORES-1:0]          req,
    input  logic [NUM_CORES-1:0]          req_rd,
    input  logic [NUM_CORES-1:0]          req_wr,
    input  logic [NUM_CORES*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   req_data,
    output logic [NUM_CORES-1:0]          ccu_ready,
    output logic [DATA_W-1:0]             data_out_ccu,
    output logic [1:0]                    upd_state,
    output logic [NUM_CORES-1:0]          snp_req,
    output logic [NUM_CORES-1:0]          snp_inv,
    output logic [ADDR_W-1:0]             snp_addr,
    output logic [1:0]                    snp_state,
    input  logic [NUM_CORES-1:0]          snp_ack,
    input  logic [NUM_CORES-1:0]          snp_hit,
    input  logic [NUM_CORES-1:0]          snp_dirty,
    input  logic [NUM_CORES*DATA_W-1:0]   snp_data,
    output logic                          mem_rd,
    output logic                          mem_wr,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ack
);

    ccu_state_t          r_state;
    ccu_state_t          w_next;
    logic                r_gnt;        // requesting core
    logic                r_wr;         // latched operation is a write
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_snp_data;   // word returned by the peer snoop
    logic [DATA_W-1:0]   r_resp_data;
    mesi_t               r_upd;

    logic                w_gid;
    logic                w_gvalid;
    logic                w_sel_wr;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic [1:0]          w_peer_oh;
    logic                w_snp_ack_p;
    logic                w_snp_hit_p;
    logic                w_snp_dirty_p;
    logic [DATA_W-1:0]   w_snp_data_p;
    logic                w_unused_rd;

    ccu_rr_arbiter u_arb (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .en           (r_state == ST_IDLE),
        .served_valid (r_state == ST_RESP),
        .grant_id     (w_gid),
        .grant_valid  (w_gvalid)
    );

    // Write wins when both op bits are set, read when neither is, so only
    // req_wr decides the operation
    assign w_unused_rd = &{1'b0, req_rd};

    assign w_sel_wr   = w_gid ? req_wr[1] : req_wr[0];
    assign w_sel_addr = w_gid ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    assign w_sel_data = w_gid ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];

    // Peer-side snoop response; the requester's own ack lines are ignored
    assign w_peer_oh     = r_gnt ? 2'b01 : 2'b10;
    assign w_snp_ack_p   = r_gnt ? snp_ack[0]   : snp_ack[1];
    assign w_snp_hit_p   = r_gnt ? snp_hit[0]   : snp_hit[1];
    assign w_snp_dirty_p = r_gnt ? snp_dirty[0] : snp_dirty[1];
    assign w_snp_data_p  = r_gnt ? snp_data[DATA_W-1:0] : snp_data[2*DATA_W-1:DATA_W];

    assign snp_addr     = r_addr;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_snp_data;
    assign data_out_ccu = r_resp_data;
    assign upd_state    = r_upd;

    // State register plus the transaction datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_snp_data  <= '0;
            r_resp_data <= '0;
            r_upd       <= MESI_I;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_gvalid) begin
                        r_gnt   <= w_gid;
                        r_wr    <= w_sel_wr;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_data;
                    end
                end
                ST_SNOOP: begin
                    if (w_snp_ack_p) begin
                        r_snp_data  <= w_snp_data_p;
                        r_resp_data <= r_wr ? r_wdata : w_snp_data_p;
                        r_upd       <= r_wr ? MESI_M : (w_snp_hit_p ? MESI_S : MESI_E);
                    end
                end
                ST_MEM_RD: begin
                    if (mem_ack) begin
                        r_resp_data <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state decode and Moore strobes
    always_comb begin
        w_next    = r_state;
        ccu_ready = '0;
        snp_req   = '0;
        snp_inv   = '0;
        snp_state = MESI_I;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gvalid) begin
                    w_next = ST_SNOOP;
                end
            end
            ST_SNOOP: begin
                if (r_wr) begin
                    snp_inv   = w_peer_oh;
                    snp_state = MESI_I;
                end else begin
                    snp_req   = w_peer_oh;
                    snp_state = MESI_S;
                end
                if (w_snp_ack_p) begin
                    if (w_snp_hit_p && w_snp_dirty_p) begin
                        w_next = ST_WB;
                    end else if (!r_wr && !w_snp_hit_p) begin
                        w_next = ST_MEM_RD;
                    end else begin
                        w_next = ST_RESP;
                    end
                end
            end
            ST_WB: begin
                mem_wr = 1'b1;
                if (mem_ack) begin
                    w_next = ST_RESP;
                end
            end
            ST_MEM_RD: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                ccu_ready = r_gnt ? 2'b10 : 2'b01;
                w_next    = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule : mesi_ccu
`default_nettype wire

// File: tb/tb_mesi_ccu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mesi_ccu
//  Description : Directed self-checking bench for mesi_ccu. The bench plays
//                both L1 controllers and the memory with hand-set responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mesi_ccu;

    logic        clk;
    logic        rst;
    logic [1:0]  req, req_rd, req_wr;
    logic [63:0] req_addr, req_data;
    logic [1:0]  ccu_ready;
    logic [31:0] data_out_ccu;
    logic [1:0]  upd_state;
    logic [1:0]  snp_req, snp_inv;
    logic [31:0] snp_addr;
    logic [1:0]  snp_state;
    logic [1:0]  snp_ack, snp_hit, snp_dirty;
    logic [63:0] snp_data;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int checks;
    int errors;

    mesi_ccu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .ccu_ready    (ccu_ready),
        .data_out_ccu (data_out_ccu),
        .upd_state    (upd_state),
        .snp_req      (snp_req),
        .snp_inv      (snp_inv),
        .snp_addr     (snp_addr),
        .snp_state    (snp_state),
        .snp_ack      (snp_ack),
        .snp_hit      (snp_hit),
        .snp_dirty    (snp_dirty),
        .snp_data     (snp_data),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; req = 0; req_rd = 0; req_wr = 0; req_addr = 0; req_data = 0;
        snp_ack = 0; snp_hit = 0; snp_dirty = 0; snp_data = 0; mem_rdata = 0; mem_ack = 0;
        @(negedge clk); @(negedge clk);
        checks++; if ({ccu_ready, snp_req, snp_inv, mem_rd, mem_wr} !== 8'h00) begin
            errors++; $display("FAIL reset_strobes got=%h exp=00", {ccu_ready, snp_req, snp_inv, mem_rd, mem_wr}); end
        checks++; if (upd_state !== 2'b11 || snp_state !== 2'b11) begin
            errors++; $display("FAIL reset_states got upd=%b snp=%b exp=11/11", upd_state, snp_state); end
        checks++; if ({data_out_ccu, mem_addr, snp_addr, mem_wdata} !== 128'h0) begin
            errors++; $display("FAIL reset_data got=%h exp=0", {data_out_ccu, mem_addr, snp_addr, mem_wdata}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Core 0 read miss; mem_ack high early and the requester's own ack must be ignored
    task automatic test_read_miss();
        req = 2'b01; req_rd = 2'b01; req_wr = 2'b00; req_addr = {32'h0, 32'h0000_1040};
        snp_ack = 2'b11; snp_hit = 2'b00; snp_dirty = 2'b00; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (snp_req !== 2'b10 || snp_state !== 2'b10 || mem_rd !== 1'b0) begin
            errors++; $display("FAIL rmiss_snoop got req=%b st=%b mrd=%b exp=10/10/0", snp_req, snp_state, mem_rd); end
        @(negedge clk);
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 32'h0000_1040 || snp_req !== 2'b00) begin
            errors++; $display("FAIL rmiss_memrd got mrd=%b addr=%h snp=%b exp=1/00001040/00", mem_rd, mem_addr, snp_req); end
        @(negedge clk);
        checks++; if (ccu_ready !== 2'b01 || data_out_ccu !== 32'hDEAD_BEEF || upd_state !== 2'b01) begin
            errors++; $display("FAIL rmiss_resp got rdy=%b data=%h upd=%b exp=01/deadbeef/01", ccu_ready, data_out_ccu, upd_state); end
        req = 0; snp_ack = 0; mem_ack = 0;
        @(negedge clk);
        checks++; if (ccu_ready !== 2'b00 || mem_rd !== 1'b0) begin
            errors++; $display("FAIL rmiss_pulse got rdy=%b mrd=%b exp=00/0", ccu_ready, mem_rd); end
    endtask

    // Core 1 read, core 0 holds the line dirty: write back then share
    task automatic test_read_hit_dirty();
        req = 2'b10; req_rd = 2'b10; req_wr = 2'b00; req_addr = {32'h0000_0200, 32'h0};
        snp_ack = 2'b01; snp_hit = 2'b01; snp_dirty = 2'b01; snp_data = {32'h0, 32'h1234_5678}; mem_ack = 1'b1;
        @(negedge clk);
        checks++; if (snp_req !== 2'b01 || snp_state !== 2'b10) begin
            errors++; $display("FAIL rdirty_snoop got req=%b st=%b exp=01/10", snp_req, snp_state); end
        @(negedge clk);
        checks++; if (mem_wr !== 1'b1 || mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h200 || mem_rd !== 1'b0) begin
            errors++; $display("FAIL rdirty_wb got wr=%b wd=%h addr=%h rd=%b exp=1/12345678/200/0", mem_wr, mem_wdata, mem_addr, mem_rd); end
        @(negedge clk);
        checks++; if (ccu_ready !== 2'b10 || data_out_ccu !== 32'h1234_5678 || upd_state !== 2'b10) begin
            errors++; $display("FAIL rdirty_resp got rdy=%b data=%h upd=%b exp=10/12345678/10", ccu_ready, data_out_ccu, upd_state); end
        req = 0; snp_ack = 0; snp_hit = 0; snp_dirty = 0; mem_ack = 0;
        @(negedge clk);
    endtask

    // Core 0 write, peer clean hit; request fields change after grant
    task automatic test_write_hit_clean();
        logic mem_seen;
        mem_seen = 1'b0;
        req = 2'b01; req_wr = 2'b01; req_rd = 2'b00; req_addr = {32'h0, 32'h300};
        req_data = {32'h0, 32'hA5A5_A5A5};
        snp_ack = 2'b10; snp_hit = 2'b10; snp_dirty = 2'b00; snp_data = {32'h7777_7777, 32'h0}; mem_ack = 1'b1;
        @(negedge clk);
        checks++; if (snp_inv !== 2'b10 || snp_req !== 2'b00 || snp_state !== 2'b11 || snp_addr !== 32'h300) begin
            errors++; $display("FAIL wr_snoop got inv=%b req=%b st=%b addr=%h exp=10/00/11/300", snp_inv, snp_req, snp_state, snp_addr); end
        if (mem_rd || mem_wr) mem_seen = 1'b1;
        req_addr = {32'h0, 32'hFFFF_0000}; req_data = {32'h0, 32'h0BAD_0BAD};
        @(negedge clk);
        if (mem_rd || mem_wr) mem_seen = 1'b1;
        checks++; if (ccu_ready !== 2'b01 || data_out_ccu !== 32'hA5A5_A5A5 || upd_state !== 2'b00) begin
            errors++; $display("FAIL wr_resp got rdy=%b data=%h upd=%b exp=01/a5a5a5a5/00", ccu_ready, data_out_ccu, upd_state); end
        checks++; if (mem_seen !== 1'b0) begin
            errors++; $display("FAIL wr_no_mem got mem_activity=%b exp=0", mem_seen); end
        req = 0; req_wr = 0; snp_ack = 0; snp_hit = 0; mem_ack = 0;
        @(negedge clk);
    endtask

    // Core 1 read miss with ack raised only in the 6th snoop and 4th memory cycle
    task automatic test_delayed_acks();
        int snp_cnt;
        int mem_cnt;
        snp_cnt = 0; mem_cnt = 0;
        req = 2'b10; req_rd = 2'b10; req_wr = 2'b00; req_addr = {32'h0000_0400, 32'h0};
        snp_ack = 0; snp_hit = 0; snp_dirty = 0; mem_ack = 0; mem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (snp_req == 2'b01) begin
                snp_cnt++;
                snp_ack = (snp_cnt == 6) ? 2'b01 : 2'b00;
            end else begin
                snp_ack = 2'b00;
                break;
            end
        end
        checks++; if (snp_cnt != 6) begin
            errors++; $display("FAIL dly_snoop_len got=%0d exp=6", snp_cnt); end
        for (int i = 0; i < 20; i++) begin
            if (mem_rd === 1'b1 && mem_addr === 32'h400) begin
                mem_cnt++;
                mem_ack = (mem_cnt == 4);
                @(negedge clk);
            end else begin
                break;
            end
        end
        mem_ack = 1'b0;
        checks++; if (mem_cnt != 4) begin
            errors++; $display("FAIL dly_mem_len got=%0d exp=4", mem_cnt); end
        checks++; if (ccu_ready !== 2'b10 || data_out_ccu !== 32'hCAFE_F00D || upd_state !== 2'b01) begin
            errors++; $display("FAIL dly_resp got rdy=%b data=%h upd=%b exp=10/cafef00d/01", ccu_ready, data_out_ccu, upd_state); end
        req = 0;
        @(negedge clk);
    endtask

    // Both cores write continuously from reset; grants must alternate
    task automatic test_back_to_back();
        logic [1:0]  order [4];
        logic [31:0] rdata [4];
        int n;
        n = 0;
        rst = 1'b1;
        req = 2'b11; req_wr = 2'b11; req_rd = 2'b00; req_addr = {32'h0000_0A00, 32'h0000_0B00};
        req_data = {32'h2222_0001, 32'h1111_0000};
        snp_ack = 2'b11; snp_hit = 2'b00; snp_dirty = 2'b00; mem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (ccu_ready != 2'b00) begin
                order[n] = ccu_ready;
                rdata[n] = data_out_ccu;
                n++;
            end
        end
        checks++; if (n != 4) begin
            errors++; $display("FAIL b2b_count got=%0d exp=4", n); end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (order[k] !== ((k % 2) ? 2'b10 : 2'b01) ||
                rdata[k] !== ((k % 2) ? 32'h2222_0001 : 32'h1111_0000)) begin
                errors++; $display("FAIL b2b_grant%0d got rdy=%b data=%h exp=%b", k, order[k], rdata[k], (k % 2) ? 2'b10 : 2'b01);
            end
        end
        req = 0; req_wr = 0; snp_ack = 0;
        @(negedge clk); @(negedge clk);
    endtask

    // Reset during MEM_RD of a core 0 read; afterwards core 0 wins a tie again
    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        req = 2'b01; req_rd = 2'b01; req_wr = 2'b00; req_addr = {32'h0, 32'h500};
        snp_ack = 2'b10; snp_hit = 2'b00; snp_dirty = 2'b00; mem_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_rd === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin
            errors++; $display("FAIL rst_reach_memrd got=0 exp=1"); end
        rst = 1'b1; mem_ack = 1'b1;
        #1;
        checks++; if (mem_rd !== 1'b0 || {ccu_ready, snp_req, snp_inv, mem_wr} !== 7'h0) begin
            errors++; $display("FAIL rst_abort got mrd=%b strobes=%h exp=0/00", mem_rd, {ccu_ready, snp_req, snp_inv, mem_wr}); end
        checks++; if (upd_state !== 2'b11 || snp_state !== 2'b11 || mem_addr !== 32'h0 || data_out_ccu !== 32'h0) begin
            errors++; $display("FAIL rst_values got upd=%b st=%b addr=%h data=%h exp=11/11/0/0", upd_state, snp_state, mem_addr, data_out_ccu); end
        req = 2'b11; req_wr = 2'b11; req_rd = 2'b00; req_data = {32'h0000_2222, 32'h0000_1111};
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (snp_inv !== 2'b10 || mem_rd !== 1'b0) begin
            errors++; $display("FAIL rst_prio got inv=%b mrd=%b exp=10/0", snp_inv, mem_rd); end
        @(negedge clk);
        checks++; if (ccu_ready !== 2'b01 || data_out_ccu !== 32'h0000_1111) begin
            errors++; $display("FAIL rst_next_resp got rdy=%b data=%h exp=01/00001111", ccu_ready, data_out_ccu); end
        req = 0; req_wr = 0; snp_ack = 0; mem_ack = 0;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_read_miss();
        test_read_hit_dirty();
        test_write_hit_clean();
        test_delayed_acks();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mesi_ccu
`default_nettype wire
